// File: rtl/regfile_context_sequencer.sv
// Context save/restore sequencer: walks an inclusive register index range, streaming
// register bytes out (save) or committing a byte stream through the write port (restore).
module regfile_context_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              save_req,
  input  logic              restore_req,
  input  logic [ADDR_W-1:0] range_lo,
  input  logic [ADDR_W-1:0] range_hi,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [7:0]        rf_read_data,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [7:0]        rf_write_data,
  output logic              rf_write_enable,
  output logic              out_valid,
  output logic [7:0]        out_data,
  output logic [ADDR_W-1:0] out_idx,
  input  logic              out_ready,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready
);

  typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] hi;
  logic              err_flag;
  logic              start;
  logic              empty;
  logic              xfer;
  logic              last;

  assign start = save_req || restore_req;
  assign empty = range_lo > range_hi;
  // The top index also ends the walk so idx can never wrap back to 0.
  assign last  = (idx == hi) || (idx == LAST_IDX);

  // Data paths are unqualified; the strobes alone say when they mean anything.
  assign out_data      = rf_read_data;
  assign rf_write_data = in_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next      = state;
    busy            = 1'b0;
    done            = 1'b0;
    err             = 1'b0;
    rf_read_addr    = '0;
    rf_write_addr   = '0;
    rf_write_enable = 1'b0;
    out_valid       = 1'b0;
    out_idx         = '0;
    in_ready        = 1'b0;
    xfer            = 1'b0;
    case (state)
      IDLE: begin
        if (save_req) begin
          state_next = empty ? DONE : SAVE;
        end else if (restore_req) begin
          state_next = empty ? DONE : RESTORE;
        end
      end
      SAVE: begin
        busy         = 1'b1;
        out_valid    = 1'b1;
        rf_read_addr = idx;
        out_idx      = idx;
        xfer         = out_ready;
        if (xfer && last) begin
          state_next = DONE;
        end
      end
      RESTORE: begin
        busy            = 1'b1;
        in_ready        = 1'b1;
        rf_write_addr   = idx;
        rf_write_enable = in_valid;
        xfer            = in_valid;
        if (xfer && last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        err        = err_flag;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx      <= '0;
      hi       <= '0;
      err_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx      <= range_lo;
            hi       <= range_hi;
            err_flag <= empty;
          end
        end
        SAVE, RESTORE: begin
          if (xfer && !last) begin
            idx <= idx + 1'b1;
          end
        end
        DONE: err_flag <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_context_sequencer.sv
// Randomized bench for regfile_context_sequencer against a transaction-level model
// of the register file contents and the expected save/restore byte sequence.
module tb_regfile_context_sequencer;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              save_req;
  logic              restore_req;
  logic [ADDR_W-1:0] range_lo;
  logic [ADDR_W-1:0] range_hi;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] rf_read_addr;
  logic [7:0]        rf_read_data;
  logic [ADDR_W-1:0] rf_write_addr;
  logic [7:0]        rf_write_data;
  logic              rf_write_enable;
  logic              out_valid;
  logic [7:0]        out_data;
  logic [ADDR_W-1:0] out_idx;
  logic              out_ready;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;

  logic [7:0]        rf [NUM_REGS];
  logic [7:0]        model_rf [NUM_REGS];
  logic              pre_we;
  logic [ADDR_W-1:0] pre_addr;
  logic [7:0]        pre_data;
  logic [7:0]        din_q [$];
  int                n_checks = 0;
  int                n_fail = 0;

  always #5 clk = ~clk;

  regfile_context_sequencer #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .save_req(save_req), .restore_req(restore_req),
    .range_lo(range_lo), .range_hi(range_hi), .busy(busy), .done(done), .err(err),
    .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
    .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .rf_write_enable(rf_write_enable), .out_valid(out_valid), .out_data(out_data),
    .out_idx(out_idx), .out_ready(out_ready), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready)
  );

  // Register file: combinational read, write on the clock edge; the bench
  // port is only used for preloading while the sequencer is idle.
  assign rf_read_data = rf[rf_read_addr];
  always @(posedge clk) begin
    if (pre_we) rf[pre_addr] <= pre_data;
    else if (rf_write_enable) rf[rf_write_addr] <= rf_write_data;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".busy"}, busy, 0);
    check_eq({tag, ".done"}, done, 0);
    check_eq({tag, ".err"}, err, 0);
    check_eq({tag, ".out_valid"}, out_valid, 0);
    check_eq({tag, ".in_ready"}, in_ready, 0);
    check_eq({tag, ".we"}, rf_write_enable, 0);
    check_eq({tag, ".rd_addr"}, rf_read_addr, 0);
    check_eq({tag, ".wr_addr"}, rf_write_addr, 0);
    check_eq({tag, ".out_idx"}, out_idx, 0);
  endtask

  task automatic compare_rf();
    for (int i = 0; i < NUM_REGS; i++) check_eq($sformatf("rf[%0d]", i), rf[i], model_rf[i]);
  endtask

  // op: 0 save, 1 restore, 2 both requests (save expected). Each cycle the bench
  // decides ready/valid; the model knows which index the k-th transfer must hit.
  // abort_k >= 0 pulls reset during the cycle presenting byte k.
  task automatic run_op(input int op, input int lo, input int hi, input bit use_pat,
                        input logic [31:0] pat, input int stall_pct, input bit noise,
                        input int abort_k);
    int n, k, c;
    bit go, is_save;
    logic [7:0] d;
    is_save = (op != 1);
    n = (lo > hi) ? 0 : hi - lo + 1;
    save_req    = (op != 1);
    restore_req = (op != 0);
    range_lo    = 4'(lo);
    range_hi    = 4'(hi);
    out_ready   = 1'b0;
    in_valid    = 1'b0;
    #1 check_idle("start");
    @(posedge clk); #1;
    save_req    = 1'b0;
    restore_req = 1'b0;
    k = 0;
    c = 1;
    while (k < n && c < 500) begin
      go = use_pat ? ((c <= 32) ? pat[c-1] : 1'b1) : ($urandom_range(99) >= stall_pct);
      d  = 8'($urandom);
      if (!is_save && go && din_q.size() > 0) d = din_q.pop_front();
      if (is_save) out_ready = go;
      else begin
        in_valid = go;
        in_data  = d;
      end
      if (noise) begin
        save_req    = 1'($urandom_range(1));
        restore_req = 1'($urandom_range(1));
        range_lo    = 4'($urandom);
        range_hi    = 4'($urandom);
      end
      if (abort_k >= 0 && k == abort_k) reset = 1'b0;
      #1;
      check_eq("busy", busy, 1);
      check_eq("done_early", done, 0);
      if (is_save) begin
        check_eq("out_valid", out_valid, 1);
        check_eq("in_ready_in_save", in_ready, 0);
        check_eq("we_in_save", rf_write_enable, 0);
        check_eq("out_idx", out_idx, lo + k);
        check_eq("out_data", out_data, model_rf[lo+k]);
      end else begin
        check_eq("in_ready", in_ready, 1);
        check_eq("out_valid_in_restore", out_valid, 0);
        check_eq("we", rf_write_enable, go);
        if (go) begin
          check_eq("wr_addr", rf_write_addr, lo + k);
          check_eq("wr_data", rf_write_data, d);
          model_rf[lo+k] = d;
        end
      end
      if (go) k++;
      @(posedge clk); #1;
      c++;
      if (!reset) begin
        check_idle("after_reset");
        reset = 1'b1;
        save_req = 1'b0;
        restore_req = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b0;
        return;
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    #1;
    check_eq("done", done, 1);
    check_eq("err", err, n == 0);
    check_eq("busy_in_done", busy, 1);
    check_eq("out_valid_in_done", out_valid, 0);
    check_eq("in_ready_in_done", in_ready, 0);
    check_eq("we_in_done", rf_write_enable, 0);
    @(posedge clk); #1;
    save_req    = 1'b0;
    restore_req = 1'b0;
    #1 check_idle("after_done");
  endtask

  initial begin
    reset       = 1'b0;
    save_req    = 1'b0;
    restore_req = 1'b0;
    range_lo    = '0;
    range_hi    = '0;
    out_ready   = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    pre_we      = 1'b0;
    pre_addr    = '0;
    pre_data    = '0;
    repeat (3) @(posedge clk);
    #1 check_idle("reset");
    reset = 1'b1;

    for (int i = 0; i < NUM_REGS; i++) begin
      pre_we      = 1'b1;
      pre_addr    = 4'(i);
      pre_data    = 8'(16 + i);
      model_rf[i] = 8'(16 + i);
      @(posedge clk); #1;
    end
    pre_we = 1'b0;

    run_op(0, 0, 15, 1, '1, 0, 0, -1);
    compare_rf();

    din_q = '{8'hA1, 8'hA2, 8'hA3};
    run_op(1, 4, 6, 1, 32'b11001, 0, 0, -1);
    compare_rf();

    run_op(0, 3, 5, 1, 32'b101001, 0, 0, -1);
    run_op(2, 0, 0, 1, '1, 0, 1, -1);
    run_op(0, 9, 2, 1, '1, 0, 0, -1);
    compare_rf();

    run_op(1, 0, 15, 1, '1, 0, 0, 2);
    repeat (3) begin
      #1;
      check_eq("no_done_after_reset", done, 0);
      check_eq("idle_after_reset", busy, 0);
      @(posedge clk); #1;
    end
    compare_rf();
    run_op(0, 0, 15, 1, '1, 0, 0, -1);

    for (int t = 0; t < 40; t++) begin
      run_op($urandom_range(2), $urandom_range(15), $urandom_range(15), 0, '0, 30, 1, -1);
    end
    compare_rf();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
